// File: rtl/i2c_slave_regbank_pkg.sv
// Shared defaults, constants and FSM encoding for the
// i2c slave register bank and its event FIFO.
package i2c_slave_regbank_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int ADDR_W_DEF     = 8;
  localparam int NUM_REGS_DEF   = 32;
  localparam int RO_BASE_DEF    = 24;
  localparam int FIFO_DEPTH_DEF = 4;

  localparam int RD_OOR_VALUE   = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_COMMIT
  } wr_state_e;

endpackage

// File: rtl/i2c_evt_fifo.sv
// Synchronous first-word fall-through FIFO carrying
// {addr,data} write events; reports drops when full.
module i2c_evt_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 4
)(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         full,
  output logic         drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          empty, do_push, do_pop;

  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == FULL_CNT);
    do_pop  = pop && !empty;
    // a pop in the same cycle frees the slot being written
    do_push = push && (!full || do_pop);
    drop    = push && full && !do_pop;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    cnt_d = cnt_q + (AW+1)'(do_push)
                  - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign valid = !empty;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/i2c_slave_regbank.sv
// Register bank behind an i2c slave: I2C-writable low
// region, system-writable high region, write event queue.
module i2c_slave_regbank
  import i2c_slave_regbank_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int NUM_REGS   = NUM_REGS_DEF,
  parameter int RO_BASE    = RO_BASE_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              i2c_wr_en,
  input  logic [ADDR_W-1:0] i2c_reg_addr,
  input  logic [DATA_W-1:0] i2c_wr_data,
  output logic [DATA_W-1:0] i2c_rd_data,
  input  logic              sys_wr_en,
  input  logic [ADDR_W-1:0] sys_addr,
  input  logic [DATA_W-1:0] sys_wdata,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [ADDR_W-1:0] evt_addr,
  output logic [DATA_W-1:0] evt_data,
  output logic              evt_overflow,
  input  logic              ovf_clear,
  output logic [15:0]       wr_count
);

  localparam int IW = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] RO_A = ADDR_W'(RO_BASE);
  localparam logic [ADDR_W-1:0] NR_A = ADDR_W'(NUM_REGS);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  wr_state_e         state_q, state_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [15:0]       wr_count_q, wr_count_d;
  logic              ovf_q, ovf_d;

  logic              i2c_acc, sys_acc, rd_hit;
  logic [IW-1:0]     i2c_idx, sys_idx;
  logic              fifo_drop, fifo_full;
  logic [ADDR_W+DATA_W-1:0] fifo_dout;

  assign i2c_idx = i2c_reg_addr[IW-1:0];
  assign sys_idx = sys_addr[IW-1:0];

  always_comb begin
    rd_hit  = (i2c_reg_addr < NR_A);
    // strobes are >= 2 cycles apart, so CAPTURE never sees one
    i2c_acc = i2c_wr_en
           && (i2c_reg_addr < RO_A)
           && rd_hit
           && (state_q != ST_CAPTURE);
    sys_acc = sys_wr_en
           && (sys_addr >= RO_A)
           && (sys_addr < NR_A);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i2c_wr_en) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        state_d = i2c_wr_en ? ST_CAPTURE : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    regs_d = regs_q;
    if (i2c_acc) regs_d[i2c_idx] = i2c_wr_data;
    if (sys_acc) regs_d[sys_idx] = sys_wdata;

    rd_data_d = rd_hit ? regs_q[i2c_idx]
                       : DATA_W'(RD_OOR_VALUE);
    wr_count_d = wr_count_q + 16'(i2c_acc);

    ovf_d = ovf_q;
    if (ovf_clear) ovf_d = 1'b0;
    if (fifo_drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      regs_q     <= '{default: '0};
      rd_data_q  <= '0;
      wr_count_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      regs_q     <= regs_d;
      rd_data_q  <= rd_data_d;
      wr_count_q <= wr_count_d;
      ovf_q      <= ovf_d;
    end
  end

  i2c_evt_fifo #(
    .W     (ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (i2c_acc),
    .din   ({i2c_reg_addr, i2c_wr_data}),
    .pop   (evt_ready),
    .dout  (fifo_dout),
    .valid (evt_valid),
    .full  (fifo_full),
    .drop  (fifo_drop)
  );

  assign evt_addr     = fifo_dout[ADDR_W+DATA_W-1:DATA_W];
  assign evt_data     = fifo_dout[DATA_W-1:0];
  assign i2c_rd_data  = rd_data_q;
  assign evt_overflow = ovf_q;
  assign wr_count     = wr_count_q;

endmodule

// File: tb/tb_i2c_slave_regbank.sv
// Scoreboard bench for i2c_slave_regbank: directed cases
// then random traffic against a queue/array reference.
module tb_i2c_slave_regbank;

  localparam int NR    = 32;
  localparam int RO    = 24;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } evt_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        i2c_wr_en;
  logic [7:0]  i2c_reg_addr;
  logic [31:0] i2c_wr_data;
  logic [31:0] i2c_rd_data;
  logic        sys_wr_en;
  logic [7:0]  sys_addr;
  logic [31:0] sys_wdata;
  logic        evt_valid;
  logic        evt_ready;
  logic [7:0]  evt_addr;
  logic [31:0] evt_data;
  logic        evt_overflow;
  logic        ovf_clear;
  logic [15:0] wr_count;

  evt_t        exp_q[$];
  logic [31:0] mregs [NR];
  logic [15:0] mcount;
  logic        movf;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  i2c_slave_regbank dut (
    .clk          (clk),
    .reset        (reset),
    .i2c_wr_en    (i2c_wr_en),
    .i2c_reg_addr (i2c_reg_addr),
    .i2c_wr_data  (i2c_wr_data),
    .i2c_rd_data  (i2c_rd_data),
    .sys_wr_en    (sys_wr_en),
    .sys_addr     (sys_addr),
    .sys_wdata    (sys_wdata),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_addr     (evt_addr),
    .evt_data     (evt_data),
    .evt_overflow (evt_overflow),
    .ovf_clear    (ovf_clear),
    .wr_count     (wr_count)
  );

  task automatic check(string name,
                       logic [63:0] act,
                       logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < NR; i++) mregs[i] = '0;
    mcount = '0;
    movf   = 1'b0;
  endtask

  // one I2C write strobe followed by one idle cycle
  task automatic i2c_wr(input logic [7:0]  a,
                        input logic [31:0] d,
                        input logic        rdy,
                        input logic        clr);
    logic acc;
    acc       = (a < RO);
    evt_ready = rdy;
    ovf_clear = clr;
    if (clr) movf = 1'b0;
    if (acc) begin
      mregs[a[4:0]] = d;
      mcount++;
      if (exp_q.size() >= DEPTH && !rdy)
        movf = 1'b1;
      else
        exp_q.push_back(evt_t'({a, d}));
    end
    i2c_wr_en    = 1'b1;
    i2c_reg_addr = a;
    i2c_wr_data  = d;
    tick();
    i2c_wr_en = 1'b0;
    ovf_clear = 1'b0;
    tick();
  endtask

  task automatic sys_wr(input logic [7:0]  a,
                        input logic [31:0] d);
    sys_wr_en = 1'b1;
    sys_addr  = a;
    sys_wdata = d;
    if (a >= RO && a < NR) mregs[a[4:0]] = d;
    tick();
    sys_wr_en = 1'b0;
  endtask

  task automatic rd_chk(input logic [7:0] a);
    logic [31:0] exp;
    exp = '0;
    if (a < NR) exp = mregs[a[4:0]];
    i2c_reg_addr = a;
    tick();
    check($sformatf("rd[%0h]", a), i2c_rd_data, exp);
  endtask

  task automatic drain();
    evt_ready = 1'b1;
    for (int i = 0; i < 4 * DEPTH && evt_valid; i++)
      tick();
    tick();
    check("drain_valid", evt_valid, 0);
    check("drain_missing", exp_q.size(), 0);
  endtask

  // monitor: every handshake must match the oldest expected event
  always @(negedge clk) begin
    if (reset === 1'b1 && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL evt_unexpected: got %0h/%0h expected none",
                 evt_addr, evt_data);
      end else begin
        evt_t e;
        e = exp_q.pop_front();
        check("evt_addr", evt_addr, e.a);
        check("evt_data", evt_data, e.d);
      end
    end
  end

  initial begin
    logic [31:0] old;
    reset        = 1'b0;
    i2c_wr_en    = 1'b0;
    i2c_reg_addr = '0;
    i2c_wr_data  = '0;
    sys_wr_en    = 1'b0;
    sys_addr     = '0;
    sys_wdata    = '0;
    evt_ready    = 1'b0;
    ovf_clear    = 1'b0;
    model_reset();
    tick();
    tick();
    check("rst_rd", i2c_rd_data, 0);
    check("rst_valid", evt_valid, 0);
    check("rst_eaddr", evt_addr, 0);
    check("rst_edata", evt_data, 0);
    check("rst_ovf", evt_overflow, 0);
    check("rst_cnt", wr_count, 0);
    reset = 1'b1;
    tick();

    // basic writes, one into the read-only region
    i2c_wr(8'h00, 32'hA1A1, 1'b0, 1'b0);
    i2c_wr(8'h0A, 32'hB2B2, 1'b0, 1'b0);
    i2c_wr(8'h10, 32'hC3C3, 1'b0, 1'b0);
    i2c_wr(8'h1A, 32'hDDDD, 1'b0, 1'b0);
    check("cnt3", wr_count, mcount);
    rd_chk(8'h00);
    rd_chk(8'h0A);
    rd_chk(8'h10);
    rd_chk(8'h1A);
    drain();

    // overflow with consumer stalled
    for (int i = 0; i < 5; i++)
      i2c_wr(8'(i), 32'h5000_0000 + 32'(i), 1'b0, 1'b0);
    check("ovf_set", evt_overflow, movf);
    check("cnt8", wr_count, mcount);
    rd_chk(8'h04);
    drain();
    ovf_clear = 1'b1;
    movf      = 1'b0;
    tick();
    ovf_clear = 1'b0;
    check("ovf_clr", evt_overflow, 0);

    // push and pop together while full
    for (int i = 0; i < 4; i++)
      i2c_wr(8'(8 + i), 32'h6000_0000 + 32'(i), 1'b0, 1'b0);
    i2c_wr(8'h0C, 32'h6666_0004, 1'b1, 1'b0);
    check("pp_ovf", evt_overflow, 0);
    drain();

    // clear and new overflow in the same cycle
    for (int i = 0; i < 4; i++)
      i2c_wr(8'(16 + i), 32'h7000_0000 + 32'(i), 1'b0, 1'b0);
    i2c_wr(8'h14, 32'h7777_0004, 1'b0, 1'b1);
    check("ovf_setwins", evt_overflow, movf);
    ovf_clear = 1'b1;
    movf      = 1'b0;
    tick();
    ovf_clear = 1'b0;
    drain();

    // read-only region
    sys_wr(8'h18, 32'h55AA55AA);
    rd_chk(8'h18);
    i2c_wr(8'h18, 32'h12345678, 1'b1, 1'b0);
    rd_chk(8'h18);
    sys_wr(8'h05, 32'hBAD0BAD0);
    rd_chk(8'h05);
    check("ro_cnt", wr_count, mcount);

    // out of range
    rd_chk(8'h40);
    i2c_wr(8'h40, 32'hFFFF0000, 1'b1, 1'b0);
    check("oor_cnt", wr_count, mcount);
    rd_chk(8'h40);

    // readback of a register written in the same cycle
    old          = mregs[7];
    mregs[7]     = 32'hDEAD0007;
    mcount++;
    exp_q.push_back(evt_t'({8'h07, 32'hDEAD0007}));
    i2c_wr_en    = 1'b1;
    i2c_reg_addr = 8'h07;
    i2c_wr_data  = 32'hDEAD0007;
    tick();
    i2c_wr_en = 1'b0;
    check("rdw_old", i2c_rd_data, old);
    tick();
    check("rdw_new", i2c_rd_data, mregs[7]);
    drain();

    // random traffic
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0, 1: i2c_wr(8'($urandom_range(0, 8'h2F)),
                     $urandom,
                     ($urandom_range(0, 2) == 0),
                     ($urandom_range(0, 7) == 0));
        2: sys_wr(8'($urandom_range(0, 8'h2F)),
                  $urandom);
        default: rd_chk(8'($urandom_range(0, 8'h2F)));
      endcase
    end
    check("rnd_cnt", wr_count, mcount);
    check("rnd_ovf", evt_overflow, movf);
    drain();
    for (int i = 0; i < NR; i++) rd_chk(8'(i));

    // reset with events queued
    for (int i = 0; i < 3; i++)
      i2c_wr(8'(i), 32'h9000_0000 + 32'(i), 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid", evt_valid, 0);
    model_reset();
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("arst_cnt", wr_count, 0);
    check("arst_ovf", evt_overflow, 0);
    rd_chk(8'h00);
    rd_chk(8'h01);
    rd_chk(8'h0A);
    rd_chk(8'h18);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
